// File: rtl/enco_coriente_pkg.sv
// Shared types and constants for the BCD current-value to indicator-level encoder.
package enco_coriente_pkg;

    localparam int unsigned ACC_W        = 14;
    localparam logic [3:0]  IND_MAX      = 4'd15;
    localparam int unsigned STEP_DEFAULT = 125;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_DIV,
        ST_ROUND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/enco_coriente_bcd_a_bin.sv
// Sequential 4-digit BCD to binary accumulator: load latches digits, each step folds in one digit, MS first.
module bcd_a_bin
    import enco_coriente_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [3:0]       dig_3,
    input  logic [3:0]       dig_2,
    input  logic [3:0]       dig_1,
    input  logic [3:0]       dig_0,
    output logic [ACC_W-1:0] acc,
    output logic             last
);

    logic [15:0]      dig_q, dig_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]       cnt_q, cnt_d;

    always_comb begin
        dig_d = dig_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load) begin
            dig_d = {dig_3, dig_2, dig_1, dig_0};
            acc_d = '0;
            cnt_d = '0;
        end else if (step) begin
            // acc*10 as (acc<<3)+(acc<<1); BCD inputs keep it within 9999
            acc_d = (acc_q << 3) + (acc_q << 1) + {{(ACC_W-4){1'b0}}, dig_q[15:12]};
            dig_d = {dig_q[11:0], 4'h0};
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            dig_q <= dig_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc  = acc_q;
    assign last = (cnt_q == 2'd3);

endmodule

// File: rtl/enco_coriente.sv
// Encodes a 4-digit BCD current value (mA) into a 4-bit indicator level: divide by STEP, round half up, saturate at 15.
module enco_coriente
    import enco_coriente_pkg::*;
#(
    parameter int unsigned STEP = STEP_DEFAULT
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] n_3C,
    input  logic [3:0] n_2C,
    input  logic [3:0] n_1C,
    input  logic [3:0] n_0C,
    output logic       busy,
    output logic       done,
    output logic [3:0] indicadorCoriente,
    output logic       error,
    output logic       saturado
);

    localparam logic [ACC_W-1:0] STEP_V = ACC_W'(STEP);

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       ind_q, ind_d;
    logic             err_q, err_d;
    logic             sat_q, sat_d;
    logic [ACC_W-1:0] rem_q, rem_d;
    logic [3:0]       quo_q, quo_d;
    logic [3:0]       it_q, it_d;

    logic             bcd_load, bcd_step, bcd_last;
    logic [ACC_W-1:0] bcd_acc;
    logic [ACC_W-1:0] div_src;
    logic             bad_digit;

    bcd_a_bin u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (bcd_load),
        .step  (bcd_step),
        .dig_3 (n_3C),
        .dig_2 (n_2C),
        .dig_1 (n_1C),
        .dig_0 (n_0C),
        .acc   (bcd_acc),
        .last  (bcd_last)
    );

    assign bad_digit = (n_3C > 4'd9) || (n_2C > 4'd9) || (n_1C > 4'd9) || (n_0C > 4'd9);

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ind_d    = ind_q;
        err_d    = err_q;
        sat_d    = sat_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        it_d     = it_q;
        bcd_load = 1'b0;
        bcd_step = 1'b0;
        div_src  = rem_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bcd_load = 1'b1;
                    busy_d   = 1'b1;
                    if (bad_digit) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        rem_d   = '0;
                        quo_d   = '0;
                        it_d    = '0;
                        state_d = ST_CONV;
                    end
                end
            end
            ST_CONV: begin
                bcd_step = 1'b1;
                if (bcd_last) begin
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                // first iteration takes the freshly accumulated value directly
                div_src = (it_q == 4'd0) ? bcd_acc : rem_q;
                if ((div_src >= STEP_V) && (quo_q < IND_MAX)) begin
                    rem_d = div_src - STEP_V;
                    quo_d = quo_q + 4'd1;
                end else begin
                    rem_d = div_src;
                end
                it_d = it_q + 4'd1;
                if (it_q == 4'd15) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if ((quo_q == IND_MAX) && (rem_q >= STEP_V)) begin
                    sat_d = 1'b1;
                    ind_d = quo_q;
                end else begin
                    sat_d = 1'b0;
                    if ((quo_q < IND_MAX) && ({rem_q, 1'b0} >= {1'b0, STEP_V})) begin
                        quo_d = quo_q + 4'd1;
                        ind_d = quo_q + 4'd1;
                    end else begin
                        ind_d = quo_q;
                    end
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // error requests arrive here with no pulse yet; issue it one cycle later
                if (done_q) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ind_q   <= '0;
            err_q   <= 1'b0;
            sat_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            it_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ind_q   <= ind_d;
            err_q   <= err_d;
            sat_q   <= sat_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            it_q    <= it_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign indicadorCoriente = ind_q;
    assign error             = err_q;
    assign saturado          = sat_q;

endmodule

// File: tb/tb_enco_coriente.sv
// Self-checking bench for enco_coriente against an arithmetic divide/round/clamp reference model.
module tb_enco_coriente;

    localparam int STEP = 125;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] n_3C, n_2C, n_1C, n_0C;
    logic       busy, done, error, saturado;
    logic [3:0] indicadorCoriente;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: last committed indicator / saturation
    int m_ind = 0;
    int m_sat = 0;
    int m_err = 0;

    enco_coriente #(.STEP(STEP)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .n_3C              (n_3C),
        .n_2C              (n_2C),
        .n_1C              (n_1C),
        .n_0C              (n_0C),
        .busy              (busy),
        .done              (done),
        .indicadorCoriente (indicadorCoriente),
        .error             (error),
        .saturado          (saturado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // returns expected latency in edges after E0
    task automatic model(input int a, input int b, input int c, input int d, output int lat);
        int v, q, r;
        if (a > 9 || b > 9 || c > 9 || d > 9) begin
            m_err = 1;
            lat   = 1;
        end else begin
            m_err = 0;
            lat   = 21;
            v = a * 1000 + b * 100 + c * 10 + d;
            q = v / STEP;
            r = v % STEP;
            if (q >= 16) begin
                m_ind = 15;
                m_sat = 1;
            end else if (q == 15) begin
                m_ind = 15;
                m_sat = 0;
            end else begin
                m_ind = (2 * r >= STEP) ? q + 1 : q;
                m_sat = 0;
            end
        end
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n = 0;
        int idle = 0;
        bit found = 0;
        while (n < 40 && !found) begin
            @(posedge clk);
            #1;
            n++;
            if (done) found = 1;
            else if (!busy) idle++;
        end
        chk({tag, "_lat"}, found ? n : -1, exp_lat);
        chk({tag, "_busy_gap"}, idle, 0);
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, int'(done), 0);
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_ind"}, int'(indicadorCoriente), m_ind);
        chk({tag, "_sat"}, int'(saturado), m_sat);
        chk({tag, "_err"}, int'(error), m_err);
    endtask

    task automatic run_req(input string tag, input int a, input int b, input int c, input int d);
        int lat;
        model(a, b, c, d, lat);
        @(negedge clk);
        n_3C  = 4'(a);
        n_2C  = 4'(b);
        n_1C  = 4'(c);
        n_0C  = 4'(d);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy_e0"}, int'(busy), 1);
        wait_done(tag, lat);
        check_outs(tag);
    endtask

    initial begin
        int lat;
        int dg[4];
        rst_n = 1'b0;
        start = 1'b0;
        n_3C = '0; n_2C = '0; n_1C = '0; n_0C = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ind", int'(indicadorCoriente), 0);
        chk("rst_err", int'(error), 0);
        chk("rst_sat", int'(saturado), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req("zero", 0, 0, 0, 0);
        run_req("v375", 0, 3, 7, 5);
        run_req("v437", 0, 4, 3, 7);
        run_req("v438", 0, 4, 3, 8);
        run_req("v1875", 1, 8, 7, 5);
        run_req("v1999", 1, 9, 9, 9);
        run_req("v9999", 9, 9, 9, 9);
        run_req("v0062", 0, 0, 6, 2);
        run_req("v0063", 0, 0, 6, 3);

        run_req("v625", 0, 6, 2, 5);
        run_req("bad_a", 0, 10, 0, 0);
        run_req("bad_f", 15, 0, 0, 9);
        run_req("after_bad", 0, 2, 5, 0);

        // start held high; digits change at E3; second conversion on first IDLE edge
        model(0, 3, 7, 5, lat);
        @(negedge clk);
        n_3C = 4'd0; n_2C = 4'd3; n_1C = 4'd7; n_0C = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_busy_e0", int'(busy), 1);
        repeat (3) @(posedge clk);
        #1;
        n_3C = 4'd9; n_2C = 4'd9; n_1C = 4'd9; n_0C = 4'd9;
        wait_done("hold1", 18);
        check_outs("hold1");
        model(9, 9, 9, 9, lat);
        wait_done("hold2", 22);
        start = 1'b0;
        check_outs("hold2");

        // async reset mid-conversion
        run_req("pre_rst", 0, 6, 2, 5);
        model(0, 4, 3, 8, lat);
        @(negedge clk);
        n_3C = 4'd0; n_2C = 4'd4; n_1C = 4'd3; n_0C = 4'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_ind", int'(indicadorCoriente), 0);
        chk("arst_err", int'(error), 0);
        chk("arst_sat", int'(saturado), 0);
        m_ind = 0; m_sat = 0; m_err = 0;
        begin
            int dones = 0;
            repeat (3) begin
                @(posedge clk);
                #1;
                if (done) dones++;
            end
            @(negedge clk);
            rst_n = 1'b1;
            repeat (25) begin
                @(posedge clk);
                #1;
                if (done || busy) dones++;
            end
            chk("arst_no_done", dones, 0);
        end
        run_req("post_rst", 0, 3, 7, 5);

        // randomized requests, mostly legal digits
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < 4; k++) begin
                dg[k] = ($urandom_range(0, 19) == 0) ? int'($urandom_range(10, 15))
                                                     : int'($urandom_range(0, 9));
            end
            if (i % 3 == 0) dg[0] = int'($urandom_range(0, 2));
            run_req("rnd", dg[0], dg[1], dg[2], dg[3]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
